// File: rtl/mmio_bus_controller.sv
// Registered memory-mapped bus controller: base/mask decode, per-slave wait states,
// ready/error handshake. Optional error address capture: MMIO_ERR_CAPTURE_EN.
module mmio_bus_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_SLV  = 3,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {32'h1001_0000, 32'h1001_0020, 32'h0040_0000},
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = {32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_0000},
  parameter logic [N_SLV-1:0]        SLV_WORD = 3'b101,
  parameter logic [N_SLV*4-1:0]      WAIT_CYC = {4'd0, 4'd1, 4'd0}
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic                    cpu_re,
  input  logic [ADDR_W-1:0]       cpu_adr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_ready,
  output logic                    cpu_err,
  output logic [N_SLV-1:0]        slv_sel,
  output logic                    slv_we,
  output logic [ADDR_W-1:0]       slv_adr,
  output logic [DATA_W-1:0]       slv_wdata,
  input  logic [N_SLV*DATA_W-1:0] slv_rdata
`ifdef MMIO_ERR_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0]       err_adr,
  output logic                    err_sticky
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  state_t              state_q;
  logic [3:0]          wait_q;
  logic                we_q;
  logic [N_SLV-1:0]    slv_sel_q;
  logic                slv_we_q;
  logic [ADDR_W-1:0]   slv_adr_q;
  logic [DATA_W-1:0]   slv_wdata_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic                cpu_ready_q;
  logic                cpu_err_q;

  logic [N_SLV-1:0]    match_d;
  logic [N_SLV-1:0]    sel_d;
  logic                word_d;
  logic [ADDR_W-1:0]   mask_d;
  logic [3:0]          wait_d;
  logic [ADDR_W-1:0]   adr_d;
  logic                bad_d;
  logic [DATA_W-1:0]   rdata_d;

`ifdef MMIO_ERR_CAPTURE_EN
  logic [ADDR_W-1:0]   err_adr_q;
  logic                err_sticky_q;
`endif

  // Window decode with lowest-index priority, address translation and read-data mux
  always_comb begin
    match_d = '0;
    word_d  = 1'b0;
    mask_d  = '0;
    wait_d  = 4'd0;
    rdata_d = '0;
    for (int i = 0; i < N_SLV; i++) begin
      match_d[i] = ((cpu_adr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]);
    end
    // isolate the lowest set bit so overlapping windows go to the lowest index
    sel_d = match_d & (~match_d + N_SLV'(1'b1));
    for (int i = 0; i < N_SLV; i++) begin
      word_d  = word_d | (sel_d[i] & SLV_WORD[i]);
      mask_d  = mask_d | ({ADDR_W{sel_d[i]}} & SLV_MASK[i*ADDR_W +: ADDR_W]);
      wait_d  = wait_d | ({4{sel_d[i]}} & WAIT_CYC[i*4 +: 4]);
      rdata_d = rdata_d | ({DATA_W{slv_sel_q[i]}} & slv_rdata[i*DATA_W +: DATA_W]);
    end
    adr_d = word_d ? ((cpu_adr & ~mask_d) >> 2'd2) : cpu_adr;
    bad_d = ~(|match_d) | (word_d & (cpu_adr[1:0] != 2'b00));
  end

  // Bus FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wait_q      <= 4'd0;
      we_q        <= 1'b0;
      slv_sel_q   <= '0;
      slv_we_q    <= 1'b0;
      slv_adr_q   <= '0;
      slv_wdata_q <= '0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_err_q   <= 1'b0;
`ifdef MMIO_ERR_CAPTURE_EN
      err_adr_q    <= '0;
      err_sticky_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          cpu_ready_q <= 1'b0;
          cpu_err_q   <= 1'b0;
          cpu_rdata_q <= '0;
          if (cpu_req && (cpu_we || cpu_re)) begin
            if (bad_d) begin
              state_q     <= ST_RESP;
              cpu_ready_q <= 1'b1;
              cpu_err_q   <= 1'b1;
`ifdef MMIO_ERR_CAPTURE_EN
              err_adr_q    <= cpu_adr;
              err_sticky_q <= 1'b1;
`endif
            end else begin
              state_q     <= ST_ACCESS;
              we_q        <= cpu_we;
              wait_q      <= wait_d;
              slv_sel_q   <= sel_d;
              slv_adr_q   <= adr_d;
              slv_wdata_q <= cpu_wdata;
              slv_we_q    <= cpu_we && (wait_d == 4'd0);
            end
          end
        end
        ST_ACCESS: begin
          if (wait_q == 4'd0) begin
            state_q     <= ST_RESP;
            slv_sel_q   <= '0;
            slv_we_q    <= 1'b0;
            cpu_ready_q <= 1'b1;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= we_q ? '0 : rdata_d;
          end else begin
            wait_q   <= wait_q - 4'd1;
            // strobe lands exactly on the cycle whose counter reads zero
            slv_we_q <= we_q && (wait_q == 4'd1);
          end
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          cpu_ready_q <= 1'b0;
          cpu_err_q   <= 1'b0;
          cpu_rdata_q <= '0;
        end
        default: begin
          state_q     <= ST_IDLE;
          slv_sel_q   <= '0;
          slv_we_q    <= 1'b0;
          cpu_ready_q <= 1'b0;
          cpu_err_q   <= 1'b0;
          cpu_rdata_q <= '0;
        end
      endcase
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign cpu_err   = cpu_err_q;
  assign slv_sel   = slv_sel_q;
  assign slv_we    = slv_we_q;
  assign slv_adr   = slv_adr_q;
  assign slv_wdata = slv_wdata_q;
`ifdef MMIO_ERR_CAPTURE_EN
  assign err_adr    = err_adr_q;
  assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_mmio_bus_controller.sv
// Directed bench for mmio_bus_controller; checks MMIO_ERR_CAPTURE_EN ports when defined.
module tb_mmio_bus_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_re;
  logic [31:0] cpu_adr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready, cpu_err;
  logic [2:0]  slv_sel;
  logic        slv_we;
  logic [31:0] slv_adr, slv_wdata;
  logic [95:0] slv_rdata;
`ifdef MMIO_ERR_CAPTURE_EN
  logic [31:0] err_adr;
  logic        err_sticky;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mmio_bus_controller dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .slv_sel(slv_sel), .slv_we(slv_we), .slv_adr(slv_adr),
    .slv_wdata(slv_wdata), .slv_rdata(slv_rdata)
`ifdef MMIO_ERR_CAPTURE_EN
    , .err_adr(err_adr), .err_sticky(err_sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic req, input logic we, input logic re,
                       input logic [31:0] adr, input logic [31:0] wd);
    cpu_req = req; cpu_we = we; cpu_re = re; cpu_adr = adr; cpu_wdata = wd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rdata"}, cpu_rdata, 64'd0);
    chk({tag, ".ready"}, cpu_ready, 64'd0);
    chk({tag, ".err"},   cpu_err,   64'd0);
    chk({tag, ".sel"},   slv_sel,   64'd0);
    chk({tag, ".we"},    slv_we,    64'd0);
    chk({tag, ".adr"},   slv_adr,   64'd0);
    chk({tag, ".wdata"}, slv_wdata, 64'd0);
  endtask

  initial begin
    slv_rdata = {32'h5555_AAAA, 32'h0000_0077, 32'hDEAD_BEEF};
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(); step();
    chk_all_zero("rst");
`ifdef MMIO_ERR_CAPTURE_EN
    chk("rst.err_sticky", err_sticky, 64'd0);
`endif
    reset = 1'b0;
    step();

    // ROM read: slave 0, word index 2, ready two cycles after request
    drive(1'b1, 1'b0, 1'b1, 32'h0040_0008, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rom.sel", slv_sel, 64'h1);
    chk("rom.adr", slv_adr, 64'h2);
    chk("rom.we", slv_we, 64'd0);
    chk("rom.ready_early", cpu_ready, 64'd0);
    step();
    chk("rom.ready", cpu_ready, 64'd1);
    chk("rom.rdata", cpu_rdata, 64'hDEAD_BEEF);
    chk("rom.err", cpu_err, 64'd0);
    chk("rom.sel_resp", slv_sel, 64'd0);
    step();
    chk("rom.ready_after", cpu_ready, 64'd0);

    // GPIO write at overlap address: GPIO wins, one wait state; inputs changed mid-access
    drive(1'b1, 1'b1, 1'b0, 32'h1001_0024, 32'h0000_00A5);
    step();
    drive(1'b0, 1'b1, 1'b1, 32'h0040_0000, 32'hFFFF_FFFF);
    chk("gpio.sel1", slv_sel, 64'h2);
    chk("gpio.adr1", slv_adr, 64'h1001_0024);
    chk("gpio.wdata1", slv_wdata, 64'hA5);
    chk("gpio.we1", slv_we, 64'd0);
    chk("gpio.ready1", cpu_ready, 64'd0);
    step();
    chk("gpio.sel2", slv_sel, 64'h2);
    chk("gpio.adr2", slv_adr, 64'h1001_0024);
    chk("gpio.we2", slv_we, 64'd1);
    chk("gpio.ready2", cpu_ready, 64'd0);
    step();
    chk("gpio.ready", cpu_ready, 64'd1);
    chk("gpio.rdata", cpu_rdata, 64'd0);
    chk("gpio.err", cpu_err, 64'd0);
    chk("gpio.we_resp", slv_we, 64'd0);
    step();

    // RAM write with we and re both set: treated as write, word index 0x40
    drive(1'b1, 1'b1, 1'b1, 32'h1001_0100, 32'h0000_1234);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("ram.sel", slv_sel, 64'h4);
    chk("ram.adr", slv_adr, 64'h40);
    chk("ram.wdata", slv_wdata, 64'h1234);
    chk("ram.we", slv_we, 64'd1);
    step();
    chk("ram.ready", cpu_ready, 64'd1);
    chk("ram.rdata", cpu_rdata, 64'd0);
    chk("ram.err", cpu_err, 64'd0);
    chk("ram.we_resp", slv_we, 64'd0);
    step();

    // RAM read just past the GPIO window: word index 0xC, data slice 2
    drive(1'b1, 1'b0, 1'b1, 32'h1001_0030, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("ramrd.sel", slv_sel, 64'h4);
    chk("ramrd.adr", slv_adr, 64'hC);
    step();
    chk("ramrd.rdata", cpu_rdata, 64'h5555_AAAA);
    step();

    // Request with neither we nor re stays idle
    drive(1'b1, 1'b0, 1'b0, 32'h0040_0000, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("nop.sel", slv_sel, 64'd0);
    chk("nop.ready", cpu_ready, 64'd0);
    step();
    chk("nop.ready2", cpu_ready, 64'd0);

    // Unmapped read: error response one cycle after request
    drive(1'b1, 1'b0, 1'b1, 32'h2000_0000, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("unmap.ready", cpu_ready, 64'd1);
    chk("unmap.err", cpu_err, 64'd1);
    chk("unmap.rdata", cpu_rdata, 64'd0);
    chk("unmap.sel", slv_sel, 64'd0);
    chk("unmap.we", slv_we, 64'd0);
    step();
    chk("unmap.ready_after", cpu_ready, 64'd0);
    chk("unmap.err_after", cpu_err, 64'd0);

    // Misaligned read in word-addressed RAM window
    drive(1'b1, 1'b0, 1'b1, 32'h1001_0002, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("misal.ready", cpu_ready, 64'd1);
    chk("misal.err", cpu_err, 64'd1);
    chk("misal.sel", slv_sel, 64'd0);
    chk("misal.we", slv_we, 64'd0);
`ifdef MMIO_ERR_CAPTURE_EN
    chk("misal.err_adr", err_adr, 64'h1001_0002);
    chk("misal.err_sticky", err_sticky, 64'd1);
`endif
    step();

    // Back-to-back ROM reads with cpu_req held high
    drive(1'b1, 1'b0, 1'b1, 32'h0040_0004, 32'h0);
    step();
    chk("b2b.sel1", slv_sel, 64'h1);
    chk("b2b.adr1", slv_adr, 64'h1);
    step();
    chk("b2b.ready1", cpu_ready, 64'd1);
    cpu_adr = 32'h0040_000C;
    step();
    chk("b2b.idle_ready", cpu_ready, 64'd0);
    chk("b2b.idle_sel", slv_sel, 64'd0);
    step();
    chk("b2b.sel2", slv_sel, 64'h1);
    chk("b2b.adr2", slv_adr, 64'h3);
    chk("b2b.ready_mid", cpu_ready, 64'd0);
    step();
    chk("b2b.ready2", cpu_ready, 64'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("b2b.ready_end", cpu_ready, 64'd0);
    chk("b2b.sel_end", slv_sel, 64'd0);

    // Reset during the first ACCESS cycle of a GPIO write
    drive(1'b1, 1'b1, 1'b0, 32'h1001_0024, 32'h0000_00A5);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("midrst.sel_before", slv_sel, 64'h2);
    reset = 1'b1;
    step();
    chk_all_zero("midrst");
`ifdef MMIO_ERR_CAPTURE_EN
    chk("midrst.err_sticky", err_sticky, 64'd0);
`endif
    reset = 1'b0;
    step();
    chk("midrst.we_after", slv_we, 64'd0);
    chk("midrst.sel_after", slv_sel, 64'd0);
    chk("midrst.ready_after", cpu_ready, 64'd0);

    // Controller is back in IDLE: a fresh GPIO read completes with normal latency
    drive(1'b1, 1'b0, 1'b1, 32'h1001_0028, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("post.sel", slv_sel, 64'h2);
    step();
    chk("post.ready_early", cpu_ready, 64'd0);
    step();
    chk("post.ready", cpu_ready, 64'd1);
    chk("post.rdata", cpu_rdata, 64'h77);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mmio_bus_controller.md
Name: mmio_bus_controller

Overview:
- Registered, parametrised memory-mapped bus controller between the RISC-V core's load/store port and N slaves (ROM, RAM, GPIO, ...).
- Decodes each address against per-slave base/mask windows, with the lowest index winning on overlap.
- Drives a one-hot slave select and translated address, inserts per-slave wait states, and returns read data with a ready/error handshake.
- Successor to the combinational peripheral decoder: adds configurable slave count, a request/ready protocol, wait states and unmapped/misaligned bus errors.

Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- N_SLV, 3: number of slaves, 1..8.
- SLV_BASE, {32'h1001_0000, 32'h1001_0020, 32'h0040_0000}: flattened N_SLV*ADDR_W base addresses; slice i = slave i; defaults are RAM=2, GPIO=1, ROM=0.
- SLV_MASK, {32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_0000}: flattened window masks. Slave i matches when (adr & MASK_i) == BASE_i.
- SLV_WORD, 3'b101: bit i=1 means slave i receives a word index; bit i=0 means it receives the full byte address.
- WAIT_CYC, {4'd0, 4'd1, 4'd0}: flattened N_SLV*4 extra wait cycles per slave.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  access request; sampled only in IDLE.
- cpu_we  in  1  write request.
- cpu_re  in  1  read request.
- cpu_adr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  bus error flag; valid with cpu_ready.
- slv_sel  out  N_SLV  one-hot slave select.
- slv_we  out  1  write strobe.
- slv_adr  out  ADDR_W  translated slave address.
- slv_wdata  out  DATA_W  latched write data.
- slv_rdata  in  N_SLV*DATA_W  flattened slave read data; slice i from slave i.

Behaviour:
- Reset: every output is 0, state is IDLE, wait counter is 0. Applies in any state, including mid-ACCESS; no slv_we is issued in the cycle after reset.
- States are IDLE, ACCESS and RESP.
- IDLE:
  - Accept when cpu_req=1 and (cpu_we | cpu_re). If both are set, the access is a write.
  - Latch we, wdata and the decoded slave. Slave address: (adr & ~MASK_i) >> 2 if SLV_WORD[i]=1, else adr.
  - No match, or SLV_WORD[i]=1 with adr[1:0]≠0 → RESP with error latched. No slave is selected and no slv_we is issued.
  - Valid match → ACCESS, counter loaded with WAIT_CYC[i].
  - cpu_req=0, or cpu_req=1 with we=re=0, → stay in IDLE.
- ACCESS:
  - slv_sel, slv_adr and slv_wdata are held stable for the whole state.
  - Counter decrements each cycle. When it is 0: latch rdata slice i (forced to 0 for writes) and go to RESP.
  - slv_we=1 only in the final ACCESS cycle (counter=0), for writes only.
- RESP:
  - cpu_ready=1 for exactly one cycle. cpu_rdata is the latched data (0 on error or write); cpu_err is the latched error.
  - slv_sel=0. Next state is IDLE.
- Latency, request cycle to ready: 2+WAIT_CYC[i] cycles. Error response: 1 cycle.
- Maximum throughput: one access per 3+WAIT_CYC[i] cycles.
- CPU inputs are ignored outside IDLE; the CPU need not hold them after acceptance.
- cpu_ready and cpu_err are 0 in IDLE and ACCESS.
- Overlapping windows resolve to the lowest index, so GPIO (1) takes precedence over RAM (2) at 0x1001_0024.

Optional Feature:
- Macro: MMIO_ERR_CAPTURE_EN.
- When defined, adds output err_adr (ADDR_W) and output err_sticky (1). On each error response, err_adr captures the offending cpu_adr and err_sticky sets.
- Both err_adr and err_sticky clear only on reset; a later error overwrites err_adr.
- When not defined, those ports and registers do not exist. Behaviour is otherwise identical.

Test Plan:
- Read 0x0040_0008 with slv_rdata slice0=0xDEAD_BEEF → slv_sel=001, slv_adr=2, cpu_ready 2 cycles after request, cpu_rdata=0xDEAD_BEEF, cpu_err=0.
- Write 0xA5 to 0x1001_0024 → slv_sel=010, slv_adr=0x1001_0024, ACCESS lasts 2 cycles, slv_we high only in the 2nd, cpu_ready 3 cycles after request.
- Write 0x1234 to 0x1001_0100 → RAM selected, slv_adr=0x40, single slv_we pulse, cpu_rdata=0, cpu_err=0.
- Read 0x2000_0000 (unmapped), then read 0x1001_0002 (misaligned) → each gets cpu_ready+cpu_err one cycle after request; slv_sel and slv_we stay 0. With MMIO_ERR_CAPTURE_EN: err_adr=0x1001_0002, err_sticky=1.
- Back-to-back requests with cpu_req held high → second access accepted in the first IDLE after RESP; exactly one ready per access.
- Assert reset during a GPIO write's first ACCESS cycle → next cycle all outputs 0, no slv_we pulse, state IDLE.
